// File: rtl/bcd_calc_ctrl_pkg.sv
// Shared definitions for the 4-digit BCD calculator sequencer:
// state encoding, key codes and the default operand width.
package bcd_calc_ctrl_pkg;

  localparam int DIGITS_DEF = 4;

  localparam logic [3:0] KEY_ADD_DEF = 4'd10;
  localparam logic [3:0] KEY_SUB_DEF = 4'd11;
  localparam logic [3:0] KEY_EQ_DEF  = 4'd12;
  localparam logic [3:0] KEY_CLR_DEF = 4'd13;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_NEGATE  = 3'd3,
    ST_SHOW    = 3'd4
  } state_e;

  function automatic logic is_digit_key(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_calc_ctrl_if.sv
// Key input, shared digit-unit handshake and display outputs of the
// calculator sequencer. The sequencer uses the slave side.
interface bcd_calc_ctrl_if
  import bcd_calc_ctrl_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF
) ();

  logic [3:0]          key_i;
  logic                key_valid_i;
  logic [3:0]          alu_a_o;
  logic [3:0]          alu_b_o;
  logic                alu_cin_o;
  logic                alu_sub_o;
  logic [3:0]          alu_res_i;
  logic                alu_cout_i;
  logic [4*DIGITS-1:0] disp_o;
  logic                busy_o;
  logic                neg_o;
  logic                ovf_o;

  modport slave (
    input  key_i, key_valid_i, alu_res_i, alu_cout_i,
    output alu_a_o, alu_b_o, alu_cin_o, alu_sub_o,
    output disp_o, busy_o, neg_o, ovf_o
  );

  modport master (
    output key_i, key_valid_i, alu_res_i, alu_cout_i,
    input  alu_a_o, alu_b_o, alu_cin_o, alu_sub_o,
    input  disp_o, busy_o, neg_o, ovf_o
  );

endinterface

// File: rtl/bcd_entry_reg.sv
// DIGITS-deep BCD operand register: shift a digit in at digit 0,
// parallel load, or clear. Clear wins over load, load over shift.
module bcd_entry_reg
  import bcd_calc_ctrl_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                load_i,
  input  logic [4*DIGITS-1:0] load_val_i,
  input  logic                shift_i,
  input  logic [3:0]          digit_i,
  output logic [4*DIGITS-1:0] q_o
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (load_i) begin
      q_d = load_val_i;
    end else if (shift_i) begin
      // top digit falls off the end of the shift
      q_d = (q_q << 4) | W'(digit_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/bcd_calc_ctrl.sv
// Keypress sequencer for the BCD calculator: builds operands A and B and
// schedules the external single-digit add/sub unit, LS digit first.
//
//   state    | meaning
//   ENTER_A  | digit keys shift into A
//   ENTER_B  | digit keys shift into B, '+'/'-' replace the op
//   COMPUTE  | A op B, one digit per cycle, carry/borrow chained
//   NEGATE   | 0 - R after a final borrow, gives the magnitude
//   SHOW     | result on display; digit restarts, '+'/'-' chains R into A
module bcd_calc_ctrl
  import bcd_calc_ctrl_pkg::*;
#(
  parameter int         DIGITS  = DIGITS_DEF,
  parameter logic [3:0] KEY_ADD = KEY_ADD_DEF,
  parameter logic [3:0] KEY_SUB = KEY_SUB_DEF,
  parameter logic [3:0] KEY_EQ  = KEY_EQ_DEF,
  parameter logic [3:0] KEY_CLR = KEY_CLR_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  bcd_calc_ctrl_if.slave  bus
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_e           state_q, state_d;
  logic             op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     r_q, r_d;
  logic [W-1:0]     disp_q, disp_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;

  logic [W-1:0] a_q, b_q;
  logic         a_clr, a_load, a_shift, b_clr, b_shift;
  logic [W-1:0] a_load_val;

  logic       key_dig, key_op, key_sub, key_eq, key_clr;
  logic [3:0] a_dig, b_dig, r_dig;
  logic [3:0] alu_a, alu_b;
  logic       alu_cin, alu_sub;
  logic       busy;

  assign key_dig = bus.key_valid_i && is_digit_key(bus.key_i);
  assign key_sub = (bus.key_i == KEY_SUB);
  assign key_op  = bus.key_valid_i && ((bus.key_i == KEY_ADD) || key_sub);
  assign key_eq  = bus.key_valid_i && (bus.key_i == KEY_EQ);
  assign key_clr = bus.key_valid_i && (bus.key_i == KEY_CLR);

  assign busy = (state_q == ST_COMPUTE) || (state_q == ST_NEGATE);

  bcd_entry_reg #(.DIGITS(DIGITS)) u_reg_a (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (a_clr),
    .load_i     (a_load),
    .load_val_i (a_load_val),
    .shift_i    (a_shift),
    .digit_i    (bus.key_i),
    .q_o        (a_q)
  );

  bcd_entry_reg #(.DIGITS(DIGITS)) u_reg_b (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (b_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .shift_i    (b_shift),
    .digit_i    (bus.key_i),
    .q_o        (b_q)
  );

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    r_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
        r_dig = r_q[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    r_d        = r_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
    a_clr      = 1'b0;
    a_load     = 1'b0;
    a_load_val = '0;
    a_shift    = 1'b0;
    b_clr      = 1'b0;
    b_shift    = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_cin    = 1'b0;
    alu_sub    = 1'b0;

    case (state_q)
      ST_ENTER_A: begin
        if (key_dig) begin
          a_shift = 1'b1;
        end else if (key_op) begin
          op_d    = key_sub;
          b_clr   = 1'b1;
          state_d = ST_ENTER_B;
        end
      end

      ST_ENTER_B: begin
        if (key_dig) begin
          b_shift = 1'b1;
        end else if (key_op) begin
          op_d = key_sub;
        end else if (key_eq) begin
          neg_d   = 1'b0;
          ovf_d   = 1'b0;
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = ST_COMPUTE;
        end
      end

      ST_COMPUTE: begin
        alu_a   = a_dig;
        alu_b   = b_dig;
        alu_cin = carry_q;
        alu_sub = op_q;
        carry_d = bus.alu_cout_i;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          carry_d = 1'b0;
          if (op_q && bus.alu_cout_i) begin
            state_d = ST_NEGATE;
          end else begin
            ovf_d   = ~op_q & bus.alu_cout_i;
            state_d = ST_SHOW;
          end
        end
      end

      ST_NEGATE: begin
        alu_b   = r_dig;
        alu_cin = carry_q;
        alu_sub = 1'b1;
        carry_d = bus.alu_cout_i;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          carry_d = 1'b0;
          neg_d   = 1'b1;
          state_d = ST_SHOW;
        end
      end

      ST_SHOW: begin
        if (key_dig) begin
          a_load     = 1'b1;
          a_load_val = W'(bus.key_i);
          b_clr      = 1'b1;
          neg_d      = 1'b0;
          ovf_d      = 1'b0;
          state_d    = ST_ENTER_A;
        end else if (key_op && !neg_q && !ovf_q) begin
          // chain the result as the next A operand
          a_load     = 1'b1;
          a_load_val = r_q;
          op_d       = key_sub;
          b_clr      = 1'b1;
          state_d    = ST_ENTER_B;
        end
      end

      default: state_d = ST_ENTER_A;
    endcase

    if (busy) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_q == IDX_W'(i)) begin
          r_d[4*i +: 4] = bus.alu_res_i;
        end
      end
    end

    if (key_clr) begin
      state_d = ST_ENTER_A;
      op_d    = 1'b0;
      idx_d   = '0;
      carry_d = 1'b0;
      r_d     = '0;
      neg_d   = 1'b0;
      ovf_d   = 1'b0;
      a_clr   = 1'b1;
      b_clr   = 1'b1;
    end
  end

  always_comb begin
    disp_d = disp_q;
    case (state_q)
      ST_ENTER_A:                       disp_d = a_q;
      ST_ENTER_B, ST_COMPUTE, ST_NEGATE: disp_d = b_q;
      ST_SHOW:                          disp_d = r_q;
      default:                          disp_d = '0;
    endcase
    if (key_clr) begin
      disp_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_ENTER_A;
      op_q    <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      r_q     <= '0;
      disp_q  <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      r_q     <= r_d;
      disp_q  <= disp_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.alu_a_o   = alu_a;
  assign bus.alu_b_o   = alu_b;
  assign bus.alu_cin_o = alu_cin;
  assign bus.alu_sub_o = alu_sub;
  assign bus.disp_o    = disp_q;
  assign bus.busy_o    = busy;
  assign bus.neg_o     = neg_q;
  assign bus.ovf_o     = ovf_q;

endmodule

// File: tb/tb_bcd_calc_ctrl.sv
// Scoreboard bench for bcd_calc_ctrl: an integer-arithmetic calculator
// model predicts results; a monitor checks them when busy_o falls.
module tb_bcd_calc_ctrl;

  localparam int DIGITS = 4;
  localparam logic [3:0] K_ADD = 4'd10;
  localparam logic [3:0] K_SUB = 4'd11;
  localparam logic [3:0] K_EQ  = 4'd12;
  localparam logic [3:0] K_CLR = 4'd13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_calc_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_calc_ctrl #(.DIGITS(DIGITS)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  // external single-digit BCD add/sub unit
  always_comb begin
    int s;
    s = 0;
    if (!bus.alu_sub_o) begin
      s = int'(bus.alu_a_o) + int'(bus.alu_b_o) + int'(bus.alu_cin_o);
      bus.alu_cout_i = (s > 9);
      bus.alu_res_i  = (s > 9) ? 4'(s - 10) : 4'(s);
    end else begin
      s = int'(bus.alu_a_o) - int'(bus.alu_b_o) - int'(bus.alu_cin_o);
      bus.alu_cout_i = (s < 0);
      bus.alu_res_i  = (s < 0) ? 4'(s + 10) : 4'(s);
    end
  end

  typedef struct {
    logic [15:0] disp;
    logic        neg;
    logic        ovf;
    int          len;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  bit   expect_abort = 1'b0;

  // calculator model: 0 = entering A, 1 = entering B, 2 = showing result
  int m_st = 0, m_a = 0, m_b = 0, m_r = 0;
  bit m_sub = 1'b0, m_neg = 1'b0, m_ovf = 1'b0;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b;
    int x;
    b = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_key(input logic [3:0] k);
    exp_t e;
    bit dig;
    bit op;
    dig = (k <= 4'd9);
    op  = (k == K_ADD) || (k == K_SUB);
    e.disp = '0; e.neg = 1'b0; e.ovf = 1'b0; e.len = 0;
    if (k == K_CLR) begin
      m_st = 0; m_a = 0; m_b = 0; m_r = 0; m_sub = 0; m_neg = 0; m_ovf = 0;
    end else begin
      case (m_st)
        0: begin
          if (dig) m_a = (m_a * 10 + int'(k)) % 10000;
          else if (op) begin m_sub = (k == K_SUB); m_b = 0; m_st = 1; end
        end
        1: begin
          if (dig) m_b = (m_b * 10 + int'(k)) % 10000;
          else if (op) m_sub = (k == K_SUB);
          else if (k == K_EQ) begin
            if (!m_sub) begin
              m_r = (m_a + m_b) % 10000; m_ovf = (m_a + m_b) > 9999; m_neg = 0; e.len = 4;
            end else if (m_a >= m_b) begin
              m_r = m_a - m_b; m_neg = 0; m_ovf = 0; e.len = 4;
            end else begin
              m_r = m_b - m_a; m_neg = 1; m_ovf = 0; e.len = 8;
            end
            e.disp = to_bcd(m_r); e.neg = m_neg; e.ovf = m_ovf;
            exp_q.push_back(e);
            m_st = 2;
          end
        end
        default: begin
          if (dig) begin
            m_a = int'(k); m_b = 0; m_neg = 0; m_ovf = 0; m_st = 0;
          end else if (op && !m_neg && !m_ovf) begin
            m_a = m_r; m_b = 0; m_sub = (k == K_SUB); m_st = 1;
          end
        end
      endcase
    end
  endtask

  task automatic drive_key(input logic [3:0] k);
    @(negedge clk);
    bus.key_i = k;
    bus.key_valid_i = 1'b1;
    @(negedge clk);
    bus.key_valid_i = 1'b0;
  endtask

  task automatic check_state();
    logic [15:0] ed;
    ed = (m_st == 0) ? to_bcd(m_a) : (m_st == 1) ? to_bcd(m_b) : to_bcd(m_r);
    check("disp", 32'(bus.disp_o), 32'(ed));
    check("neg", 32'(bus.neg_o), 32'(m_neg));
    check("ovf", 32'(bus.ovf_o), 32'(m_ovf));
    check("busy_idle", 32'(bus.busy_o), 32'd0);
    check("alu_idle", 32'({bus.alu_a_o, bus.alu_b_o, bus.alu_cin_o, bus.alu_sub_o}), 32'd0);
  endtask

  task automatic press(input logic [3:0] k);
    int n;
    model_key(k);
    drive_key(k);
    n = 0;
    while (bus.busy_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy_o) begin
      n_total++;
      $display("FAIL busy_timeout: busy_o still %0b after %0d cycles", bus.busy_o, n);
    end
    @(negedge clk);
    check_state();
  endtask

  task automatic press_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "+":     press(K_ADD);
        "-":     press(K_SUB);
        "=":     press(K_EQ);
        "C":     press(K_CLR);
        default: press(4'(s[i] - "0"));
      endcase
    end
  endtask

  // monitor: result checks when busy_o falls, display one cycle later
  initial begin
    bit   busy_prev;
    int   busy_len;
    bit   disp_pending;
    logic [15:0] pend_disp;
    exp_t e;
    busy_prev = 1'b0; busy_len = 0; disp_pending = 1'b0; pend_disp = '0;
    forever begin
      @(negedge clk);
      if (disp_pending) begin
        check("res_disp", 32'(bus.disp_o), 32'(pend_disp));
        disp_pending = 1'b0;
      end
      if (bus.busy_o) begin
        busy_len++;
      end else if (busy_prev) begin
        if (expect_abort) begin
          expect_abort = 1'b0;
        end else if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: busy_o fell after %0d cycles, no result expected", busy_len);
        end else begin
          e = exp_q.pop_front();
          check("res_neg", 32'(bus.neg_o), 32'(e.neg));
          check("res_ovf", 32'(bus.ovf_o), 32'(e.ovf));
          check("busy_len", 32'(busy_len), 32'(e.len));
          pend_disp = e.disp;
          disp_pending = 1'b1;
        end
        busy_len = 0;
      end
      busy_prev = bus.busy_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    bus.key_i = '0;
    bus.key_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_disp", 32'(bus.disp_o), 32'd0);
    check("rst_flags", 32'({bus.busy_o, bus.neg_o, bus.ovf_o}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_state();

    press_str("1234+5678=");
    check("t1_disp", 32'(bus.disp_o), 32'h6912);

    press_str("-912=");
    check("chain_disp", 32'(bus.disp_o), 32'h6000);
    press_str("7");
    check("show_digit", 32'(bus.disp_o), 32'h0007);

    press_str("C9999+1=");
    check("ovf_disp", 32'(bus.disp_o), 32'h0000);
    check("ovf_flag", 32'(bus.ovf_o), 32'd1);
    press_str("+");
    check("ovf_op_ignored", 32'({bus.disp_o, bus.ovf_o}), {15'd0, 16'h0000, 1'b1});

    press_str("C12-345=");
    check("neg_disp", 32'(bus.disp_o), 32'h0333);
    check("neg_flag", 32'(bus.neg_o), 32'd1);

    press_str("C12345");
    check("shift_drop", 32'(bus.disp_o), 32'h2345);
    press_str("=");
    check("eq_in_a", 32'(bus.disp_o), 32'h2345);

    // clear two cycles into COMPUTE
    press_str("C5+5");
    drive_key(K_EQ);
    check("cmp_busy", 32'(bus.busy_o), 32'd1);
    expect_abort = 1'b1;
    model_key(K_CLR);
    drive_key(K_CLR);
    check("clr_disp", 32'(bus.disp_o), 32'd0);
    check("clr_flags", 32'({bus.busy_o, bus.neg_o, bus.ovf_o}), 32'd0);
    press_str("3");
    check("clr_enter_a", 32'(bus.disp_o), 32'h0003);

    // async reset in the middle of NEGATE
    press_str("C1-2");
    drive_key(K_EQ);
    repeat (5) @(negedge clk);
    check("negate_busy", 32'(bus.busy_o), 32'd1);
    expect_abort = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_disp", 32'(bus.disp_o), 32'd0);
    check("arst_flags", 32'({bus.busy_o, bus.neg_o, bus.ovf_o}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_key(K_CLR);
    @(negedge clk);
    check_state();

    for (int n = 0; n < 250; n++) begin
      int r;
      logic [3:0] k;
      r = $urandom_range(0, 99);
      if (r < 55)      k = 4'($urandom_range(0, 9));
      else if (r < 67) k = ($urandom_range(0, 1) == 0) ? K_ADD : K_SUB;
      else if (r < 82) k = K_EQ;
      else if (r < 86) k = K_CLR;
      else             k = 4'($urandom_range(14, 15));
      press(k);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_calc_ctrl.md
Name: bcd_calc_ctrl

Overview:
- Keypress-driven sequencer for the 4-digit BCD calculator.
- Accepts decoded key codes from the PS/2 front end and builds operands A and B by digit shifting.
- On '=', drives one shared single-digit BCD add/sub unit serially, least-significant digit first, chaining carry/borrow in a register.
- Presents the operand or result digits to the 7-segment display driver, with negative and overflow flags.

Parameters:
- DIGITS, 4, number of BCD digits per operand/result.
- KEY_ADD, 10, key code for '+'.
- KEY_SUB, 11, key code for '-'.
- KEY_EQ, 12, key code for '='.
- KEY_CLR, 13, key code for clear.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-low.
- key_i  in  4  key code; 0-9 digits, 10-13 commands, 14-15 ignored.
- key_valid_i  in  1  single-cycle strobe; key_i is valid this cycle.
- alu_a_o  out  4  digit operand A to the shared digit unit.
- alu_b_o  out  4  digit operand B.
- alu_cin_o  out  1  carry-in (add) or borrow-in (sub).
- alu_sub_o  out  1  1 = subtract, 0 = add.
- alu_res_i  in  4  combinational digit result, sampled the same cycle.
- alu_cout_i  in  1  carry-out or borrow-out.
- disp_o  out  4*DIGITS  display digits, digit 0 in bits [3:0].
- busy_o  out  1  high in COMPUTE and NEGATE.
- neg_o  out  1  result is negative; disp_o shows the magnitude.
- ovf_o  out  1  addition overflowed; disp_o shows the low DIGITS digits.

Behaviour:
- Reset (rst_i low, async):
  - A, B, R, disp_o, neg_o, ovf_o, busy_o all 0.
  - State ENTER_A, op = add, digit index 0, carry register 0.
- Key handling:
  - A key is acted on only in the cycle key_valid_i = 1.
  - At most one key per cycle. key_valid_i pulses one cycle per keypress.
- Digit entry (digit key):
  - Target operand shifts up one digit: the top digit is dropped, the new digit enters digit 0.
  - In ENTER_A the target is A; in ENTER_B the target is B.
- States and transitions:
  - ENTER_A:
    - Digit: shift into A.
    - ADD/SUB: latch op, clear B, go to ENTER_B.
    - EQ: ignored.
  - ENTER_B:
    - Digit: shift into B.
    - ADD/SUB: overwrite op; B is kept.
    - EQ: clear neg_o/ovf_o, index 0, carry 0, go to COMPUTE.
  - COMPUTE:
    - Runs DIGITS cycles.
    - Each cycle, for index i: alu_a_o = A[i], alu_b_o = B[i], alu_cin_o = carry reg, alu_sub_o = op.
    - Same cycle: R[i] <= alu_res_i, carry reg <= alu_cout_i.
    - After index DIGITS-1:
      - Add with final cout = 1: ovf_o <= 1.
      - Sub with final borrow = 1: go to NEGATE.
      - Otherwise go to SHOW.
    - All keys except CLR are ignored.
  - NEGATE:
    - Runs DIGITS cycles, computing 0 - R digit-serially (alu_a_o = 0, alu_b_o = R[i], alu_sub_o = 1, borrow chained from 0).
    - R[i] <= alu_res_i each cycle.
    - Then neg_o <= 1 and go to SHOW.
    - Keys except CLR are ignored.
  - SHOW:
    - Digit: A <= that digit only, B <= 0, clear flags, go to ENTER_A.
    - ADD/SUB with neg_o = 0 and ovf_o = 0: A <= R (chaining), latch op, B <= 0, clear flags, go to ENTER_B.
    - ADD/SUB when a flag is set: ignored.
    - EQ: ignored.
  - CLR in any state, including mid-COMPUTE or mid-NEGATE: the same clear as reset, taking effect next edge.
- Latency:
  - EQ accepted at edge t: busy_o high from t+1.
  - SHOW is entered DIGITS cycles later, or 2*DIGITS cycles later if the result is negative.
  - Flags are valid when busy_o falls.
- disp_o is registered and updated the cycle after the source changes:
  - ENTER_A shows A.
  - ENTER_B and COMPUTE/NEGATE show B.
  - SHOW shows R.
- alu_* outputs are 0 outside COMPUTE/NEGATE.
- Codes 14-15 are ignored in every state.

Decomposition:
- Shared package holds:
  - State encoding (ENTER_A, ENTER_B, COMPUTE, NEGATE, SHOW).
  - Key code constants.
  - DIGITS default.
- One natural sub-module: bcd_entry_reg, a DIGITS-deep 4-bit shift register with shift-in, parallel load and clear. It is instantiated for A and for B.
- The digit add/sub unit stays external. This block only schedules it.

Test Plan:
- Keys 1,2,3,4,+,5,6,7,8,= -> busy_o high 4 cycles; disp_o = 6912; neg_o = 0, ovf_o = 0.
- 9,9,9,9,+,1,= -> disp_o = 0000, ovf_o = 1; then '+' is ignored (state stays SHOW).
- 1,2,-,3,4,5,= -> busy_o high 8 cycles; disp_o = 0333, neg_o = 1.
- 1,2,3,4,5 -> disp_o = 2345. Then '=' in ENTER_A -> no change.
- 5,+,5,= then CLR asserted 2 cycles into COMPUTE -> next cycle all registers 0, busy_o = 0, state ENTER_A. Also pull rst_i low mid-NEGATE -> immediate reset values.
- Chaining: after 6912 shown, keys -,9,1,2,= -> disp_o = 6000. Then digit 7 in SHOW -> disp_o = 0007, state ENTER_A.
